// File: rtl/gpio_irq_ctrl.sv
// APB4 master that configures an apb4_gpio and turns its interrupts into queued {status, pins} events.
// Optional feature macro: GPIO_IRQ_CTRL_TSTAMP_EN adds a per-event cycle timestamp (evt_tstamp_o).

// Generic synchronous FIFO; first word is presented combinationally on out_dat.
// Latency: one cycle from push to out_vld.
// Backpressure: in_rdy low when full; out_dat held until out_vld && out_rdy.
module gpio_irq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit separates full from empty when the index bits match.
    assign in_rdy  = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
    assign out_vld = (wr_ptr != rd_ptr);
    assign out_dat = out_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_vld && in_rdy)   wr_ptr <= wr_ptr + 1'b1;
            if (out_vld && out_rdy) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld && in_rdy) mem[wr_ptr[AW-1:0]] <= in_dat;
    end
endmodule

// GPIO interrupt sequencer: init writes, then INTSTATUS/PADIN reads per irq into an event FIFO.
// Latency: irq seen in IDLE -> event valid 5 cycles later with zero wait states.
// Backpressure: a full FIFO holds the FSM in IDLE; the GPIO keeps irq asserted meanwhile.
module gpio_irq_ctrl #(
    parameter int          GPIO_NUM   = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [31:0] INIT_DIR   = '0,
    parameter logic [31:0] INIT_INTEN = '0,
    parameter logic [31:0] INIT_TYPE0 = '0,
    parameter logic [31:0] INIT_TYPE1 = '0
) (
    input  logic                pclk_i,
    input  logic                preset_i,
    input  logic                irq_i,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [31:0]         paddr_o,
    output logic [31:0]         pwdata_o,
    input  logic [31:0]         prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [GPIO_NUM-1:0] evt_status_o,
    output logic [GPIO_NUM-1:0] evt_pins_o,
`ifdef GPIO_IRQ_CTRL_TSTAMP_EN
    output logic [31:0]         evt_tstamp_o,
`endif
    output logic                init_done_o,
    output logic                busy_o,
    output logic                err_o,
    input  logic                err_clr_i
);
    typedef enum logic [2:0] {
        INIT_W0, INIT_W1, INIT_W2, INIT_W3, IDLE, RD_STAT, RD_PIN
    } state_t;

    localparam logic [31:0] PIN_MASK = 32'hFFFF_FFFF >> (32 - GPIO_NUM);
`ifdef GPIO_IRQ_CTRL_TSTAMP_EN
    localparam int FW = 2 * GPIO_NUM + 32;
`else
    localparam int FW = 2 * GPIO_NUM;
`endif

    state_t              state, state_nxt;
    logic                psel, psel_nxt;
    logic                penable, penable_nxt;
    logic                init_done;
    logic                err;
    logic [GPIO_NUM-1:0] stat_q;
    logic                stat_cap, push, err_set, done_set;
    logic [31:0]         offset, wdat;
    logic                wr;
    logic                fifo_rdy;
    logic [GPIO_NUM-1:0] pins_rd;
    logic [FW-1:0]       push_dat, fifo_dat;

    // psel low outside INIT_W0 means IDLE; INIT_W0 with psel low only exists right after reset.
    always_comb begin
        state_nxt   = state;
        psel_nxt    = psel;
        penable_nxt = penable;
        stat_cap    = 1'b0;
        push        = 1'b0;
        err_set     = 1'b0;
        done_set    = 1'b0;
        if (!psel) begin
            if (state == IDLE) begin
                if (irq_i && fifo_rdy) begin
                    state_nxt = RD_STAT;
                    psel_nxt  = 1'b1;
                end
            end else begin
                psel_nxt = 1'b1;
            end
        end else if (!penable) begin
            penable_nxt = 1'b1;
        end else if (pready_i) begin
            penable_nxt = 1'b0;
            case (state)
                INIT_W0: state_nxt = INIT_W1;
                INIT_W1: state_nxt = INIT_W2;
                INIT_W2: state_nxt = INIT_W3;
                INIT_W3: begin
                    state_nxt = IDLE;
                    psel_nxt  = 1'b0;
                    done_set  = 1'b1;
                end
                RD_STAT: begin
                    if (pslverr_i) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                        psel_nxt  = 1'b0;
                    end else if (prdata_i[GPIO_NUM-1:0] == '0) begin
                        state_nxt = IDLE;
                        psel_nxt  = 1'b0;
                    end else begin
                        stat_cap  = 1'b1;
                        state_nxt = RD_PIN;
                    end
                end
                RD_PIN: begin
                    push      = 1'b1;
                    err_set   = pslverr_i;
                    state_nxt = IDLE;
                    psel_nxt  = 1'b0;
                end
                default: begin
                    state_nxt = IDLE;
                    psel_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state   <= INIT_W0;
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            state   <= state_nxt;
            psel    <= psel_nxt;
            penable <= penable_nxt;
        end
    end

    always_comb begin
        offset = 32'h0;
        wdat   = 32'h0;
        wr     = 1'b0;
        case (state)
            INIT_W0: begin offset = 32'h00; wdat = INIT_DIR;   wr = 1'b1; end
            INIT_W1: begin offset = 32'h10; wdat = INIT_TYPE0; wr = 1'b1; end
            INIT_W2: begin offset = 32'h14; wdat = INIT_TYPE1; wr = 1'b1; end
            INIT_W3: begin offset = 32'h0C; wdat = INIT_INTEN; wr = 1'b1; end
            RD_STAT: offset = 32'h18;
            RD_PIN:  offset = 32'h04;
            default: offset = 32'h0;
        endcase
    end

    // Address/data derive from the held state, so they are stable across SETUP and ACCESS.
    assign psel_o    = psel;
    assign penable_o = penable;
    assign pwrite_o  = psel & wr;
    assign paddr_o   = psel ? (BASE_ADDR + offset) : 32'h0;
    assign pwdata_o  = psel ? (wdat & PIN_MASK) : 32'h0;
    assign busy_o    = psel;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            init_done <= 1'b0;
            err       <= 1'b0;
            stat_q    <= '0;
        end else begin
            if (done_set) init_done <= 1'b1;
            if (err_set)        err <= 1'b1;
            else if (err_clr_i) err <= 1'b0;
            if (stat_cap) stat_q <= prdata_i[GPIO_NUM-1:0];
        end
    end

    assign init_done_o = init_done;
    assign err_o       = err;
    assign pins_rd     = pslverr_i ? '0 : prdata_i[GPIO_NUM-1:0];

`ifdef GPIO_IRQ_CTRL_TSTAMP_EN
    logic [31:0] tstamp_cnt, tstamp_q;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            tstamp_cnt <= 32'h0;
            tstamp_q   <= 32'h0;
        end else begin
            tstamp_cnt <= tstamp_cnt + 32'h1;
            if (state == IDLE && !psel && irq_i && fifo_rdy) tstamp_q <= tstamp_cnt;
        end
    end

    assign push_dat     = {tstamp_q, stat_q, pins_rd};
    assign evt_tstamp_o = fifo_dat[FW-1:2*GPIO_NUM];
`else
    assign push_dat = {stat_q, pins_rd};
`endif

    gpio_irq_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (pclk_i),
        .rst     (preset_i),
        .in_vld  (push),
        .in_rdy  (fifo_rdy),
        .in_dat  (push_dat),
        .out_vld (evt_valid_o),
        .out_rdy (evt_ready_i),
        .out_dat (fifo_dat)
    );

    assign evt_status_o = fifo_dat[2*GPIO_NUM-1:GPIO_NUM];
    assign evt_pins_o   = fifo_dat[GPIO_NUM-1:0];
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: behavioural GPIO slave, expected-event queue and decoupled monitors.
module tb_gpio_irq_ctrl;
    localparam int          G     = 32;
    localparam int          D     = 4;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [31:0] DIR   = 32'h0000_00F0;
    localparam logic [31:0] TYPE0 = 32'h0000_000F;
    localparam logic [31:0] TYPE1 = 32'h0000_0003;
    localparam logic [31:0] INTEN = 32'h8000_00FF;

    logic          clk = 1'b0;
    logic          preset = 1'b1;
    logic          irq;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata, prdata;
    logic          pready, pslverr;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [G-1:0]  evt_status, evt_pins;
    logic          init_done, busy, err;
    logic          err_clr = 1'b0;
`ifdef GPIO_IRQ_CTRL_TSTAMP_EN
    logic [31:0]   evt_tstamp;
`endif

    gpio_irq_ctrl #(
        .GPIO_NUM(G), .FIFO_DEPTH(D), .BASE_ADDR(BASE),
        .INIT_DIR(DIR), .INIT_INTEN(INTEN), .INIT_TYPE0(TYPE0), .INIT_TYPE1(TYPE1)
    ) dut (
        .pclk_i(clk), .preset_i(preset), .irq_i(irq),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
        .pready_i(pready), .pslverr_i(pslverr),
        .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
        .evt_status_o(evt_status), .evt_pins_o(evt_pins),
`ifdef GPIO_IRQ_CTRL_TSTAMP_EN
        .evt_tstamp_o(evt_tstamp),
`endif
        .init_done_o(init_done), .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, cyc = 0;
    int stat_reads = 0, pin_reads = 0, apb_cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural GPIO slave: status clears when read; per-event wait states and error injection.
    logic [31:0] g_stat = 0, g_pins = 0, p_stat = 0, p_pins = 0;
    logic        spur = 0, e_stat = 0, e_pin = 0, p_spur = 0, p_es = 0, p_ep = 0;
    int          wcnt = 0, p_ws = 0, req = 0, ack = 0;
    logic [31:0] off;

    assign off     = paddr - BASE;
    assign irq     = (g_stat != 0) || spur;
    assign pready  = !(off == 32'h18 && wcnt != 0);
    assign prdata  = (off == 32'h18) ? g_stat : (off == 32'h04) ? g_pins : 32'h0;
    assign pslverr = psel && penable && pready &&
                     ((off == 32'h18 && e_stat) || (off == 32'h04 && e_pin));

    always @(posedge clk or posedge preset) begin
        if (preset) begin
            g_stat <= 0; g_pins <= 0; spur <= 0; e_stat <= 0; e_pin <= 0; wcnt <= 0; ack <= req;
        end else if (req != ack) begin
            g_stat <= p_stat; g_pins <= p_pins; spur <= p_spur;
            e_stat <= p_es; e_pin <= p_ep; wcnt <= p_ws; ack <= req;
        end else if (psel && penable) begin
            if (off == 32'h18) begin
                if (wcnt != 0) wcnt <= wcnt - 1;
                else begin g_stat <= 0; spur <= 0; e_stat <= 0; end
            end else if (off == 32'h04) begin
                e_pin <= 0;
            end
        end
    end

    // APB monitor: phase stability, expected init writes, read bookkeeping.
    logic [31:0] s_addr, s_dat;
    logic        s_wr;
    always @(negedge clk) begin
        if (!preset) begin
            if (psel) apb_cyc++;
            if (psel && !penable) begin s_addr = paddr; s_wr = pwrite; s_dat = pwdata; end
            if (psel && penable) begin
                chk("apb_addr_stable", paddr, s_addr);
                chk("apb_ctl_stable", {pwrite, pwdata}, {s_wr, s_dat});
                if (pready) begin
                    if (pwrite) begin
                        if (wq.size() == 0) begin
                            total++;
                            $display("FAIL apb_write: unexpected write %0h@%0h", pwdata, paddr);
                        end else begin
                            logic [63:0] w;
                            w = wq.pop_front();
                            chk("init_write_addr", paddr, w[63:32]);
                            chk("init_write_data", pwdata, w[31:0]);
                        end
                    end else if (off == 32'h18) stat_reads++;
                    else if (off == 32'h04) pin_reads++;
                end
            end
        end
    end

    // Event monitor: every accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (!preset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL evt_unexpected: status %0h pins %0h, expected none", evt_status, evt_pins);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("evt_status", evt_status, e[63:32]);
                chk("evt_pins", evt_pins, e[31:0]);
            end
        end
    end

    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic push_init_writes();
        wq.push_back({BASE + 32'h00, DIR});
        wq.push_back({BASE + 32'h10, TYPE0});
        wq.push_back({BASE + 32'h14, TYPE1});
        wq.push_back({BASE + 32'h0C, INTEN});
    endtask

    // Reference rule: an event is queued iff status != 0 and the status read did not error;
    // a PADIN error queues pins as 0.
    task automatic issue(input logic [31:0] st, input logic [31:0] pn, input logic sp,
                         input logic es, input logic ep, input int ws,
                         input bit expect_evt, input bit wt);
        int sr0;
        sr0 = stat_reads;
        p_stat = st; p_pins = pn; p_spur = sp; p_es = es; p_ep = ep; p_ws = ws;
        req++;
        if (expect_evt && st != 0 && !es) exp_q.push_back({st, ep ? 32'h0 : pn});
        @(negedge clk);
        if (wt) begin
            for (int i = 0; i < 40 && stat_reads == sr0; i++) @(negedge clk);
            chk("stat_read_seen", stat_reads != sr0, 1);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic release_and_init(input string tag);
        int rel;
        drive_slot();
        preset = 1'b0;
        push_init_writes();
        rel = cyc;
        for (int i = 0; i < 20 && !init_done; i++) @(negedge clk);
        chk({tag, "_init_done_cycle"}, cyc - rel, 9);
        chk({tag, "_init_writes_left"}, wq.size(), 0);
        chk({tag, "_idle_after_init"}, psel, 0);
    endtask

    task automatic wait_irq_get_t0(output int t0);
        for (int i = 0; i < 5 && !irq; i++) @(negedge clk);
        t0 = cyc;
    endtask

    task automatic wait_valid_latency(input int t0, input int lat, input string name);
        for (int i = 0; i < 30 && !evt_valid; i++) @(negedge clk);
        chk(name, cyc - t0, lat);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, p0, a0;
        logic [31:0] st;

        repeat (3) @(negedge clk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr_pwdata", {paddr, pwdata}, 0);
        chk("rst_outputs", {evt_valid, init_done, busy, err, pwrite}, 0);
        chk("rst_evt_data", {evt_status, evt_pins}, 0);

        release_and_init("boot");

        // Single event with a held consumer, then one pop.
        issue(32'h4, 32'h5, 0, 0, 0, 0, 1, 0);
        wait_irq_get_t0(t0);
        wait_valid_latency(t0, 5, "single_latency");
        chk("single_status", evt_status, 32'h4);
        chk("single_pins", evt_pins, 32'h5);
        chk("single_idle", busy, 0);
        drive_slot(); evt_ready = 1'b1;
        drive_slot(); evt_ready = 1'b0;
        @(negedge clk);
        chk("single_popped", evt_valid, 0);

        // Three wait states on the status read.
        issue(32'h80, 32'h1234, 0, 0, 0, 3, 1, 0);
        wait_irq_get_t0(t0);
        for (int i = 0; i < 10 && !(psel && penable); i++) @(negedge clk);
        chk("ws_busy", busy, 1);
        wait_valid_latency(t0, 8, "ws_latency");
        drive_slot(); evt_ready = 1'b1;
        drive_slot();

        // Status read error: no push, no PADIN read, sticky flag cleared by err_clr.
        p0 = pin_reads;
        issue(32'h2, 32'h7, 0, 1, 0, 0, 1, 1);
        chk("stat_err_flag", err, 1);
        chk("stat_err_no_pin_read", pin_reads - p0, 0);
        chk("stat_err_no_push", evt_valid, 0);
        drive_slot(); err_clr = 1'b1;
        drive_slot(); err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", err, 0);

        // PADIN error with err_clr held: event pushed with pins 0 and set beats clear.
        drive_slot(); err_clr = 1'b1;
        issue(32'h10, 32'hAB, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 20 && !(psel && penable && pslverr); i++) @(negedge clk);
        @(posedge clk);
        #1;
        chk("err_set_wins", err, 1);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("pin_err_sticky", err, 1);
        drive_slot(); err_clr = 1'b1;
        drive_slot(); err_clr = 1'b0;
        drain("pin_err_drain");

        // Spurious interrupt: status 0, no PADIN read, nothing queued.
        p0 = pin_reads;
        issue(32'h0, 32'h55, 1, 0, 0, 0, 1, 1);
        chk("spur_no_pin_read", pin_reads - p0, 0);
        chk("spur_no_push", evt_valid, 0);
        chk("spur_no_err", err, 0);

        // Backpressure: four fill the FIFO, the fifth waits in IDLE.
        drive_slot(); evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) issue($urandom | 32'h1, $urandom, 0, 0, 0, 0, 1, 1);
        a0 = apb_cyc;
        issue($urandom | 32'h100, $urandom, 0, 0, 0, 0, 1, 0);
        repeat (20) @(negedge clk);
        chk("full_no_apb", apb_cyc - a0, 0);
        chk("full_irq_held", irq, 1);
        chk("full_queue_depth", exp_q.size(), 5);
        p0 = stat_reads;
        drive_slot(); evt_ready = 1'b1;
        drive_slot(); evt_ready = 1'b0;
        for (int i = 0; i < 20 && stat_reads == p0; i++) @(negedge clk);
        chk("fifth_serviced", stat_reads - p0, 1);
        repeat (4) @(negedge clk);
        drive_slot(); evt_ready = 1'b1;
        drain("backpressure_drain");

        // Randomised events against the reference rule.
        for (int k = 0; k < 10; k++) begin
            st = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            issue(st, $urandom, st == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2), 1, 1);
        end
        drain("random_drain");
        drive_slot(); err_clr = 1'b1;
        drive_slot(); err_clr = 1'b0;

        // Reset in the middle of an ACCESS with one event queued.
        drive_slot(); evt_ready = 1'b0;
        issue(32'h3, 32'h9, 0, 0, 0, 0, 1, 1);
        chk("pre_reset_queued", evt_valid, 1);
        issue(32'h8, 32'h1, 0, 0, 0, 3, 0, 0);
        for (int i = 0; i < 10 && !(psel && penable); i++) @(negedge clk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        drive_slot();
        preset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_psel_penable", {psel, penable}, 0);
        chk("mid_rst_fifo_empty", evt_valid, 0);
        chk("mid_rst_flags", {init_done, busy, err, pwrite}, 0);
        chk("mid_rst_addr", paddr, 0);
        release_and_init("rerun");

        drive_slot(); evt_ready = 1'b1;
        issue(32'h4000_0000, 32'hCAFE, 0, 0, 0, 0, 1, 1);
        drain("final_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

APB4 master controller that sequences a companion `apb4_gpio` instance. After reset it writes the GPIO configuration registers, then services the GPIO interrupt. On each `irq_i` it reads INTSTATUS, which clears the interrupt, and PADIN. It queues {status, pins} events in a FIFO for a downstream consumer over a valid/ready handshake. It sits between the GPIO slave's APB port and the event-handling logic, so the CPU never polls the GPIO.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- `GPIO_NUM`, 32: pin count, 1..32.
- `FIFO_DEPTH`, 4: event FIFO entries, power of two, ≥2.
- `BASE_ADDR`, 32'h0: GPIO base address.
- `INIT_DIR`, `INIT_INTEN`, `INIT_TYPE0`, `INIT_TYPE1`, all '0: values written at init.

Ports:
- `pclk_i`  in  1  clock
- `preset_i`  in  1  asynchronous active-high reset
- `irq_i`  in  1  GPIO interrupt
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB master control
- `paddr_o`  out  32  APB address
- `pwdata_o`  out  32  APB write data
- `prdata_i`  in  32  APB read data
- `pready_i`, `pslverr_i`  in  1  APB response
- `evt_valid_o`  out  1  event available
- `evt_ready_i`  in  1  consumer accepts
- `evt_status_o`, `evt_pins_o`  out  GPIO_NUM  INTSTATUS / PADIN snapshot
- `init_done_o`  out  1  configuration complete
- `busy_o`  out  1  APB transfer in progress
- `err_o`  out  1  sticky pslverr flag
- `err_clr_i`  in  1  clears `err_o`

## Operation
- FSM states: INIT_W0..INIT_W3, IDLE, RD_STAT, RD_PIN.
- Each APB transfer has two phases:
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1, held until `pready_i`.
  - `prdata_i` and `pslverr_i` are sampled on the ACCESS edge where `pready_i`=1.
  - `paddr`, `pwrite` and `pwdata` are stable across both phases.
- INIT: four writes, in order:
  - DIR (+0x00) = INIT_DIR
  - INTTYPE0 (+0x10) = INIT_TYPE0
  - INTTYPE1 (+0x14) = INIT_TYPE1
  - INTEN (+0x0C) = INIT_INTEN

  Unused high bits are written 0. `init_done_o` rises the cycle after the last ACCESS completes, then the FSM enters IDLE.
- IDLE → RD_STAT when `irq_i`=1 and the FIFO is not full.
  - FIFO full: remain in IDLE. The GPIO holds irq/status, so no event is lost.
- RD_STAT: read +0x18 and capture status.
  - status[GPIO_NUM-1:0]==0 (spurious): return to IDLE, no push.
  - `pslverr_i`=1: set `err_o`, return to IDLE, no push.
  - otherwise → RD_PIN.
- RD_PIN: read +0x04, then push {status, pins}.
  - `pslverr_i`=1: set `err_o` and still push; pins=0.
  - Then → IDLE.
- FIFO behaviour:
  - First word is presented on `evt_*`.
  - Pop when `evt_valid_o && evt_ready_i`.
  - Simultaneous push and pop: both take effect, count unchanged.
  - Full cannot overflow, because fullness is checked before RD_STAT and only one push follows.
- `err_o`: sticky. If `err_clr_i` and a new error occur in the same cycle, set wins.
- `busy_o`=1 whenever `psel_o`=1.
- Reset, including mid-transfer:
  - `psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o` go to 0.
  - `evt_valid_o`, `evt_*`, `init_done_o`, `busy_o`, `err_o` go to 0.
  - FIFO emptied; FSM to INIT_W0; init restarts after reset release.

## Timing
- First INIT SETUP occurs in the first clock after `preset_i` deasserts.
- With `pready_i`=1, each transfer takes 2 cycles. Init completes in 8 cycles; `init_done_o` is high in cycle 9.
- `irq_i` seen in IDLE at cycle N:
  - N+1: SETUP STAT
  - N+2: ACCESS STAT; the GPIO drops irq at this edge
  - N+3: SETUP PIN
  - N+4: ACCESS PIN
  - N+5: `evt_valid_o`=1 (empty FIFO), FSM in IDLE
- Each wait state adds one cycle to the affected transfer.
- `irq_i` is re-sampled only in IDLE. An `irq_i` still high at N+5 from a new event starts another service.

## Configuration
- `GPIO_IRQ_CTRL_TSTAMP_EN` defined:
  - Adds a 32-bit free-running cycle counter, reset 0, wrapping at 2^32-1 → 0.
  - Adds output `evt_tstamp_o`[31:0], the counter value in the IDLE cycle where `irq_i` was accepted.
  - The timestamp is stored per FIFO entry.
- Undefined: no counter, no port, and FIFO width is 2*GPIO_NUM.

## Test plan
- Init sequence: release reset, `pready_i`=1, INIT_DIR=32'hF0 → writes 0xF0@+0x00, INIT_TYPE0@+0x10, INIT_TYPE1@+0x14, INIT_INTEN@+0x0C, each SETUP→ACCESS; `init_done_o`=1 at cycle 9.
- Single event: `irq_i` pulse, status 32'h4, pins 32'h5 → `evt_valid_o` at N+5, `evt_status_o`=4, `evt_pins_o`=5; `evt_ready_i` pops and `evt_valid_o`=0 next cycle.
- Backpressure: `evt_ready_i`=0, FIFO_DEPTH=4, five irqs → four entries; fifth irq waits in IDLE with no APB activity; one pop → fifth serviced, contents in order.
- Wait states and error:
  - `pready_i` low 3 cycles on STAT → signals stable, latency 8.
  - `pslverr_i` on STAT → `err_o`=1, no push; `err_clr_i` → 0.
- Spurious and reset: status read 0 → no push, no PADIN read; `preset_i` asserted during ACCESS → `psel_o`/`penable_o` 0 immediately, FIFO empty, init reruns.
